// File: rtl/xge_pkt_pkg.sv
// xge_pkt_pkg: shared FSM state type, default frame length limits and byte-lane count for the packet generator
package xge_pkt_pkg;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  localparam int unsigned MIN_LEN_DEF = 64;
  localparam int unsigned MAX_LEN_DEF = 1518;
  localparam int unsigned LANES = 8;
endpackage

// File: rtl/pkt_tx_gen_pattern.sv
// pkt_tx_gen_pattern: builds one bus word (frame, byte offset, len -> data) where byte k = frame+k and bytes at or past len are zero
module pkt_tx_gen_pattern
  import xge_pkt_pkg::*;
(
  input  logic [7:0]         frame,
  input  logic [10:0]        off,
  input  logic [10:0]        len,
  output logic [8*LANES-1:0] data
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign data[8*i+:8] = off + 11'(i) < len ? frame + off[7:0] + 8'(i) : 8'd0;
  end
endmodule

// File: rtl/pkt_tx_gen.sv
// pkt_tx_gen: MAC TX burst generator; start/cfg_len/cfg_num/cfg_gap in, pkt_tx_full backpressure in, pkt_tx_data/val/sop/eop/mod bus out, busy/done/sent_cnt status out
module pkt_tx_gen
  import xge_pkt_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned MIN_LEN = MIN_LEN_DEF
) (
  input  logic        clk_156m25,
  input  logic        reset_156m25_n,
  input  logic        start,
  input  logic [10:0] cfg_len,
  input  logic [15:0] cfg_num,
  input  logic [7:0]  cfg_gap,
  input  logic        pkt_tx_full,
  output logic [63:0] pkt_tx_data,
  output logic        pkt_tx_val,
  output logic        pkt_tx_sop,
  output logic        pkt_tx_eop,
  output logic [2:0]  pkt_tx_mod,
  output logic        busy,
  output logic        done,
  output logic [15:0] sent_cnt
);
  state_t      state_q, state_d;
  logic [10:0] len_q, len_d;
  logic [15:0] num_q, num_d;
  logic [7:0]  gap_q, gap_d;
  logic [7:0]  gcnt_q, gcnt_d;
  logic [7:0]  word_q, word_d;
  logic [7:0]  frame_q, frame_d;
  logic [15:0] sent_q, sent_d;
  logic        done_q, done_d;
  logic [63:0] data_q, data_d;
  logic        val_q, val_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic [2:0]  mod_q, mod_d;
  logic [10:0] len_c;
  logic        last;
  logic [63:0] pat;
  assign len_c = cfg_len < 11'(MIN_LEN) ? 11'(MIN_LEN) : cfg_len > 11'(MAX_LEN) ? 11'(MAX_LEN) : cfg_len;
  assign last = {3'd0, word_q} == ((len_q + 11'd7) >> 3) - 11'd1;
  pkt_tx_gen_pattern u_pat (
    .frame(frame_q),
    .off  ({word_q, 3'd0}),
    .len  (len_q),
    .data (pat)
  );
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    num_d   = num_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    word_d  = word_q;
    frame_d = frame_q;
    sent_d  = sent_q;
    done_d  = 1'b0;
    data_d  = '0;
    val_d   = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    mod_d   = 3'd0;
    if (state_q == IDLE && start) begin
      len_d   = len_c;
      num_d   = cfg_num;
      gap_d   = cfg_gap;
      word_d  = 8'd0;
      frame_d = 8'd0;
      state_d = cfg_num == 16'd0 ? IDLE : SEND;
      done_d  = cfg_num == 16'd0;
    end
    if (state_q == SEND && !pkt_tx_full) begin
      data_d = pat;
      val_d  = 1'b1;
      sop_d  = word_q == 8'd0;
      eop_d  = last;
      mod_d  = last ? len_q[2:0] : 3'd0;
      word_d = last ? 8'd0 : word_q + 8'd1;
      if (last) begin
        sent_d  = sent_q + 16'd1;
        frame_d = frame_q + 8'd1;
        num_d   = num_q - 16'd1;
        gcnt_d  = gap_q;
        state_d = gap_q != 8'd0 ? GAP : num_q != 16'd1 ? SEND : IDLE;
        done_d  = gap_q == 8'd0 && num_q == 16'd1;
      end
    end
    if (state_q == GAP) begin
      gcnt_d = gcnt_q - 8'd1;
      if (gcnt_q == 8'd1) begin
        state_d = num_q != 16'd0 ? SEND : IDLE;
        done_d  = num_q == 16'd0;
      end
    end
  end
  always_ff @(posedge clk_156m25) begin
    if (!reset_156m25_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      num_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      word_q  <= '0;
      frame_q <= '0;
      sent_q  <= '0;
      done_q  <= 1'b0;
      data_q  <= '0;
      val_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      mod_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      num_q   <= num_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      word_q  <= word_d;
      frame_q <= frame_d;
      sent_q  <= sent_d;
      done_q  <= done_d;
      data_q  <= data_d;
      val_q   <= val_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      mod_q   <= mod_d;
    end
  end
  assign pkt_tx_data = data_q;
  assign pkt_tx_val  = val_q;
  assign pkt_tx_sop  = sop_q;
  assign pkt_tx_eop  = eop_q;
  assign pkt_tx_mod  = mod_q;
  assign busy        = state_q != IDLE;
  assign done        = done_q;
  assign sent_cnt    = sent_q;
endmodule

// File: tb/tb_pkt_tx_gen.sv
// tb_pkt_tx_gen: self-checking bench with a frame-level scoreboard, vector table and hand-written corner sequences
module tb_pkt_tx_gen;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] cfg_len;
  logic [15:0] cfg_num;
  logic [7:0]  cfg_gap;
  logic        full;
  logic [63:0] data;
  logic        val, sop, eop;
  logic [2:0]  mod;
  logic        busy, done;
  logic [15:0] sent;

  typedef struct {logic [63:0] d; logic s; logic e; logic [2:0] m;} word_t;
  typedef struct {int len; int num; int gap; int words; int mod;} vec_t;

  word_t exp_q[$];
  word_t mx;
  vec_t  tv[9];
  int    n_chk = 0;
  int    n_fail = 0;
  int    exp_sent = 0;
  bit    mon_en = 0;
  bit    rand_full = 0;
  logic  full_s = 1'b0;
  logic        lv[64], ls[64], le[64], ldn[64];
  logic [2:0]  lm[64];
  logic [63:0] ld[64];

  pkt_tx_gen dut (
    .clk_156m25    (clk),
    .reset_156m25_n(rst_n),
    .start         (start),
    .cfg_len       (cfg_len),
    .cfg_num       (cfg_num),
    .cfg_gap       (cfg_gap),
    .pkt_tx_full   (full),
    .pkt_tx_data   (data),
    .pkt_tx_val    (val),
    .pkt_tx_sop    (sop),
    .pkt_tx_eop    (eop),
    .pkt_tx_mod    (mod),
    .busy          (busy),
    .done          (done),
    .sent_cnt      (sent)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int clampl(input int l);
    return l < 64 ? 64 : (l > 1518 ? 1518 : l);
  endfunction

  task automatic push_burst(input int l, input int n);
    int L, nw, k;
    word_t x;
    L  = clampl(l);
    nw = (L + 7) / 8;
    for (int f = 0; f < n; f++)
      for (int w = 0; w < nw; w++) begin
        x.d = '0;
        for (int i = 0; i < 8; i++) begin
          k = 8 * w + i;
          if (k < L) x.d[8*i+:8] = 8'((f + k) % 256);
        end
        x.s = w == 0;
        x.e = w == nw - 1;
        x.m = x.e ? 3'(L % 8) : 3'd0;
        exp_q.push_back(x);
      end
  endtask

  always @(posedge clk) full_s <= full;

  always @(negedge clk) begin
    if (mon_en) begin
      if (val) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word got=val exp=idle at %0t", $time);
        end else begin
          mx = exp_q.pop_front();
          chk("data", data, mx.d);
          chk("sop", sop, mx.s);
          chk("eop", eop, mx.e);
          chk("mod", mod, mx.m);
        end
        chk("val_after_full", full_s, 1'b0);
      end else begin
        chk("idle_data", data, 64'd0);
        chk("idle_ctl", {sop, eop, mod}, 5'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_full) full = $urandom_range(0, 3) == 0;
  endtask

  task automatic do_start(input int l, input int n, input int g, input bit acc);
    cfg_len = 11'(l);
    cfg_num = 16'(n);
    cfg_gap = 8'(g);
    start   = 1'b1;
    if (acc) begin
      push_burst(l, n);
      exp_sent += n;
    end
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (!done && c < budget) begin
      step();
      c++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  task automatic run_log(input int n, input int ff, input int ft);
    for (int j = 0; j < n; j++) begin
      step();
      full   = j >= ff && j <= ft;
      lv[j]  = val;
      ls[j]  = sop;
      le[j]  = eop;
      lm[j]  = mod;
      ld[j]  = data;
      ldn[j] = done;
    end
  endtask

  initial begin
    int fv, lx, nv, nd, e0, n2, cnt, lmod, c, l, n, g;
    tv[0] = '{20, 1, 0, 8, 0};
    tv[1] = '{2000, 1, 0, 190, 6};
    tv[2] = '{64, 1, 0, 8, 0};
    tv[3] = '{65, 2, 1, 9, 1};
    tv[4] = '{1518, 1, 2, 190, 6};
    tv[5] = '{0, 1, 0, 8, 0};
    tv[6] = '{71, 1, 0, 9, 7};
    tv[7] = '{1517, 1, 0, 190, 5};
    tv[8] = '{100, 3, 0, 13, 4};
    rst_n = 1'b0; start = 1'b0; cfg_len = '0; cfg_num = '0; cfg_gap = '0; full = 1'b0;
    step();
    step();
    chk("rst_val", val, 1'b0);
    chk("rst_data", data, 64'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sent", sent, 16'd0);
    rst_n  = 1'b1;
    mon_en = 1;
    step();

    do_start(64, 1, 0, 1);
    run_log(12, -1, -1);
    fv = -1; lx = 0; nv = 0; nd = 0;
    for (int j = 0; j < 12; j++) begin
      if (lv[j]) begin
        if (fv < 0) fv = j;
        lx = j;
        nv++;
      end
      if (ldn[j]) nd++;
    end
    if (fv < 0) fv = 0;
    chk("a_words", nv, 8);
    chk("a_consecutive", lx - fv, 7);
    chk("a_sop_first", ls[fv], 1'b1);
    chk("a_eop_last", le[lx], 1'b1);
    chk("a_mod", lm[lx], 3'd0);
    chk("a_done_once", nd, 1);
    chk("a_sent", sent, 16'd1);

    do_start(65, 2, 3, 1);
    run_log(40, -1, -1);
    fv = -1; e0 = -1; n2 = -1; nv = 0;
    for (int j = 0; j < 40; j++) begin
      if (lv[j]) begin
        nv++;
        if (fv < 0) fv = j;
        if (e0 >= 0 && n2 < 0) n2 = j;
      end
      if (le[j] && e0 < 0) e0 = j;
    end
    if (fv < 0) fv = 0;
    if (e0 < 0) e0 = 0;
    if (n2 < 0) n2 = 0;
    chk("b_words", nv, 18);
    chk("b_frame0_len", e0 - fv, 8);
    chk("b_gap_idle", n2 - e0 - 1, 3);
    chk("b_eop_mod", lm[e0], 3'd1);
    chk("b_eop_tail_zero", ld[e0] >> 8, 64'd0);
    chk("b_eop_byte0", ld[e0] & 64'hff, 64'h40);
    chk("b_f1_sop", ls[n2], 1'b1);
    chk("b_f1_byte0", ld[n2] & 64'hff, 64'h01);
    chk("b_sent", sent, 16'd3);

    do_start(100, 1, 0, 1);
    run_log(24, 3, 6);
    full = 1'b0;
    nv = 0;
    for (int j = 0; j < 24; j++) if (lv[j]) nv++;
    chk("c_words", nv, 13);
    chk("c_first", lv[0], 1'b1);
    chk("c_val_cycle3", lv[3], 1'b1);
    chk("c_stall", {lv[4], lv[5], lv[6], lv[7]}, 4'd0);
    chk("c_resume", lv[8], 1'b1);

    for (int t = 0; t < 9; t++) begin
      cnt = 0; lmod = -1; c = 0;
      do_start(tv[t].len, tv[t].num, tv[t].gap, 1);
      do begin
        step();
        if (val) cnt++;
        if (eop) lmod = int'(mod);
        c++;
      end while (!done && c < 3000);
      chk("t_done", done, 1'b1);
      chk("t_words", cnt, tv[t].words * tv[t].num);
      chk("t_last_mod", lmod, tv[t].mod);
      chk("t_sent", sent, 16'(exp_sent));
    end

    do_start(64, 0, 0, 1);
    chk("e_num0_busy", busy, 1'b0);
    chk("e_num0_done", done, 1'b1);
    step();
    chk("e_num0_done_end", done, 1'b0);
    chk("e_num0_busy2", busy, 1'b0);
    chk("e_num0_sent", sent, 16'(exp_sent));
    do_start(64, 1, 0, 1);
    step();
    chk("e_busy", busy, 1'b1);
    do_start(200, 5, 0, 0);
    wait_done(100);
    repeat (20) step();
    chk("e_ignored_sent", sent, 16'(exp_sent));
    chk("e_idle_after", busy, 1'b0);
    chk("e_queue_empty", exp_q.size(), 0);

    do_start(200, 2, 0, 1);
    cnt = 0; c = 0;
    while (cnt < 6 && c < 50) begin
      step();
      if (val) cnt++;
      c++;
    end
    chk("f_reached_word5", cnt, 6);
    rst_n = 1'b0;
    step();
    exp_q.delete();
    exp_sent = 0;
    chk("f_val", val, 1'b0);
    chk("f_data", data, 64'd0);
    chk("f_ctl", {sop, eop, mod}, 5'd0);
    chk("f_busy", busy, 1'b0);
    chk("f_done", done, 1'b0);
    chk("f_sent", sent, 16'd0);
    rst_n = 1'b1;
    step();
    do_start(64, 1, 0, 1);
    wait_done(100);
    step();
    chk("f_new_sent", sent, 16'd1);
    chk("f_new_queue", exp_q.size(), 0);

    rand_full = 1;
    repeat (15) begin
      l = $urandom_range(0, 2047);
      n = $urandom_range(1, 3);
      g = $urandom_range(0, 5);
      do_start(l, n, g, 1);
      wait_done(6000);
      chk("r_sent", sent, 16'(exp_sent));
    end
    rand_full = 0;
    full = 1'b0;
    repeat (3) step();
    chk("r_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_tx_gen.md
PKT_TX_GEN -- requirements
Module: pkt_tx_gen

Interface
REQ-001 Parameter MAX_LEN, default 1518, SHALL set the maximum frame length in bytes.
REQ-002 Parameter MIN_LEN, default 64, SHALL set the minimum frame length in bytes.
REQ-003 clk_156m25  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 reset_156m25_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 start  input  1  SHALL be a one-cycle pulse requesting a burst.
REQ-006 cfg_len  input  11  SHALL be the frame length in bytes, sampled on an accepted start.
REQ-007 cfg_num  input  16  SHALL be the number of frames in the burst, sampled on an accepted start.
REQ-008 cfg_gap  input  8  SHALL be the idle cycles after each eop, sampled on an accepted start.
REQ-009 pkt_tx_full  input  1  SHALL be MAC TX FIFO backpressure.
REQ-010 pkt_tx_data / pkt_tx_val / pkt_tx_sop / pkt_tx_eop  output  64/1/1/1  SHALL be the MAC TX packet bus.
REQ-011 pkt_tx_mod  output  3  SHALL give valid bytes in the eop word (0 = all 8).
REQ-012 busy  output  1  SHALL be high in any state other than IDLE.
REQ-013 done  output  1  SHALL pulse for one cycle at burst end.
REQ-014 sent_cnt  output  16  SHALL count frames completed since reset.

Function
REQ-015 FSM states SHALL be IDLE, SEND, GAP; start is accepted only in IDLE and ignored otherwise.
REQ-016 cfg_len below MIN_LEN SHALL be clamped to MIN_LEN; above MAX_LEN clamped to MAX_LEN.
REQ-017 Word count per frame SHALL be ceil(len/8); eop word mod = len[2:0].
REQ-018 On accepted start with cfg_num=0: no frame sent, busy stays low, done pulses the next cycle.
REQ-019 On accepted start with cfg_num>0: next state SEND; first val no earlier than the following cycle.
REQ-020 All bus outputs SHALL be registered; val in cycle n+1 only if pkt_tx_full was low in cycle n.
REQ-021 While pkt_tx_full is high, val/sop/eop SHALL be low and word/byte/frame counters hold; resume at the same word.
REQ-022 sop SHALL be high on word 0 only; eop on the last word only; both on the same word never (MIN_LEN>8).
REQ-023 Byte k of frame f SHALL equal (f[7:0]+k) mod 256, byte k in lane k mod 8 at data[8i+7:8i].
REQ-024 Bytes beyond len in the eop word SHALL be zero; mod SHALL be 0 on non-eop words.
REQ-025 After eop: sent_cnt increments (wraps 0xFFFF->0); state GAP for cfg_gap cycles (0 = skip GAP).
REQ-026 After GAP (or eop when gap=0): next frame if remaining>0, else IDLE with done pulse.
REQ-027 data/sop/eop/mod SHALL be zero whenever val is low.

Reset
REQ-028 Reset low SHALL force IDLE, all outputs 0, sent_cnt 0, latched config 0, at the next edge, including mid-frame.
REQ-029 No partial-frame completion after reset; a mid-frame eop is never issued.

Structure
REQ-030 Package xge_pkt_pkg SHALL hold the state enum, MIN_LEN/MAX_LEN defaults and byte-lane width constant.
REQ-031 One sub-module pkt_tx_gen_pattern SHALL produce the 64-bit word from frame index, byte offset and len.

Verification
REQ-032 start, len=64, num=1, gap=0, full=0 -> 8 consecutive val words, sop word0, eop word7, mod=0, done once, sent_cnt=1.
REQ-033 len=65, num=2, gap=3 -> 9 words each, eop mod=1 with bytes1..7 zero, 3 idle cycles between frames, frame1 byte0=0x01.
REQ-034 len=100, full high for cycles 3..6 of frame -> val low exactly one cycle after full rises until one after it falls, no word lost/duplicated.
REQ-035 len=20 and len=2000 -> frames of 64 and 1518 bytes (8 and 190 words, mod 0 and 6).
REQ-036 num=0 -> busy never high, done pulse one cycle after start; start while busy -> ignored, frame count unchanged.
REQ-037 reset low mid-frame word 5 -> next cycle all outputs 0, IDLE, sent_cnt 0; new start sends a clean frame from sop.
